adsr_envelope: RTL and testbench
================================

// Module: adsr_envelope
// PURPOSE
//  SID-6581-style ADSR envelope generator for one voice. Produces the 8-bit
//  linear envelope consumed by the voice amplitude modulator, which scales the
//  12-bit waveform by envelope/256. Gate edges start attack or release.
//  Decay and release follow the 6581 piecewise-exponential curve.
// PARAMETERS
//  CLK_DIV  50  clk cycles per 1 us envelope tick (tick prescaler); min 1
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst_n     in   1  synchronous reset, active-low
//  gate      in   1  voice gate; rise = attack, fall = release
//  attack    in   4  attack rate index
//  decay     in   4  decay rate index
//  sustain   in   4  sustain level nibble; level = {sustain,sustain}
//  release   in   4  release rate index
//  envelope  out  8  envelope value to the amplitude modulator (registered)
//  env_state out  2  0=ATTACK 1=DECAY_SUSTAIN 2=RELEASE (registered)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): envelope=0, env_state=RELEASE, gate_d=0,
//    prescaler/rate_cnt(15b)/exp_cnt(5b)=0. Reset mid-envelope aborts at once.
//  - Tick: prescaler counts 0..CLK_DIV-1; tick=1 on the cycle it is CLK_DIV-1.
//  - Rate period table, idx 0..15 (ticks): 9 32 63 95 149 220 267 313 392 977
//    1954 3126 3907 11720 19532 31251. Selected by attack/decay/release index
//    of the current state, read combinationally every cycle.
//  - On tick: if rate_cnt==period -> rate_cnt=0, rate_step=1; else rate_cnt+1,
//    15-bit wrap (32767->0). Step interval = period+1 ticks. A rate change
//    leaving rate_cnt>period must run to wrap: 6581 behaviour, keep it.
//  - Exp divider (DECAY_SUSTAIN, RELEASE only), by envelope: >=0x5D:1,
//    >=0x36:2, >=0x1A:4, >=0x0E:8, >=0x06:16, else 30. On rate_step:
//    exp_cnt+1>=div -> exp_cnt=0, env_step=1; else exp_cnt+1. In ATTACK,
//    exp_cnt held at 0 and env_step=rate_step.
//  - gate_d registers gate. Rise (gate&~gate_d) -> ATTACK; fall -> RELEASE.
//    On either edge rate_cnt=0, exp_cnt=0; envelope kept (no reset to 0).
//    State/counters change on the posedge after gate_d captures the edge.
//  - ATTACK: env_step -> envelope+1. Step reaching 0xFF -> DECAY_SUSTAIN in
//    the same cycle. Never wraps past 0xFF.
//  - DECAY_SUSTAIN: env_step and envelope > level -> envelope-1. Envelope <=
//    level -> hold; no climb if sustain raised. Gate stays high until release.
//  - RELEASE: env_step and envelope != 0 -> envelope-1. Hold at 0, no wrap.
//  - Edge beats a coincident env_step: the step that cycle is dropped.
//  - Output latency: envelope updates one clk after the env_step condition.
// TESTING (CLK_DIV=1 unless noted)
//  - rst_n=0 3 cycles mid-attack -> envelope=0x00, env_state=2 after 1st edge.
//  - attack=0, gate 0->1 from env 0 -> +1 every 10 clks, 0xFF at 2550+-2 clks,
//    env_state 0->1 same cycle.
//  - decay=0, sustain=8 after attack -> 0xFF down to 0x88 at 10 clks/step,
//    holds 0x88 for 5000 clks; sustain->0xF then -> stays 0x88.
//  - release=0 from 0x88, gate 1->0 -> step intervals 10/20/40/80/160/300 clks
//    in each band; ends at 0x00, stays 0 for 10000 clks.
//  - regate at env 0x40 in release -> attack resumes 0x41, 0x42.. 10 clks/step.
//  - in decay, decay=15 until rate_cnt=20000, then decay=0 -> next step after
//    12768+10 ticks (wrap), then every 10.
//  - CLK_DIV=50, attack=0 -> one step per 500 clks.

Source files
------------

// File: rtl/adsr_envelope_if.sv
// Voice control and envelope bundle between a voice controller (master) and the ADSR generator (slave).
// The release index is named release_rate because "release" is a SystemVerilog keyword.
interface adsr_envelope_if;
   logic       gate;
   logic [3:0] attack;
   logic [3:0] decay;
   logic [3:0] sustain;
   logic [3:0] release_rate;
   logic [7:0] envelope;
   logic [1:0] env_state;

   modport master (
      output gate, attack, decay, sustain, release_rate,
      input  envelope, env_state
   );

   modport slave (
      input  gate, attack, decay, sustain, release_rate,
      output envelope, env_state
   );
endinterface

// File: rtl/adsr_envelope.sv
// SID-6581-style ADSR envelope generator for one voice: linear attack and
// piecewise-exponential decay/release on a prescaled 1 us tick.
module adsr_envelope #(
   parameter int CLK_DIV = 50
) (
   input  logic           clk,
   input  logic           rst_n,
   adsr_envelope_if.slave bus
);

   localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_ATTACK        = 2'd0,
      ST_DECAY_SUSTAIN = 2'd1,
      ST_RELEASE       = 2'd2
   } env_state_e;

   env_state_e    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [14:0]   rate_cnt_q, rate_cnt_d;
   logic [4:0]    exp_cnt_q, exp_cnt_d;
   logic [7:0]    envelope_q, envelope_d;
   logic          gate_dly_q, gate_dly_d;

   logic          tick;
   logic [3:0]    rate_idx;
   logic [14:0]   period;
   logic [4:0]    exp_div;
   logic [7:0]    level;
   logic          rate_step;
   logic          env_step;
   logic          gate_rise;
   logic          gate_fall;

   function automatic logic [14:0] rate_period(input logic [3:0] idx);
      case (idx)
         4'd0:    rate_period = 15'd9;
         4'd1:    rate_period = 15'd32;
         4'd2:    rate_period = 15'd63;
         4'd3:    rate_period = 15'd95;
         4'd4:    rate_period = 15'd149;
         4'd5:    rate_period = 15'd220;
         4'd6:    rate_period = 15'd267;
         4'd7:    rate_period = 15'd313;
         4'd8:    rate_period = 15'd392;
         4'd9:    rate_period = 15'd977;
         4'd10:   rate_period = 15'd1954;
         4'd11:   rate_period = 15'd3126;
         4'd12:   rate_period = 15'd3907;
         4'd13:   rate_period = 15'd11720;
         4'd14:   rate_period = 15'd19532;
         default: rate_period = 15'd31251;
      endcase
   endfunction

   // Piecewise approximation of an exponential curve: slower steps at low levels.
   function automatic logic [4:0] exp_divider(input logic [7:0] env);
      if (env >= 8'h5D)      exp_divider = 5'd1;
      else if (env >= 8'h36) exp_divider = 5'd2;
      else if (env >= 8'h1A) exp_divider = 5'd4;
      else if (env >= 8'h0E) exp_divider = 5'd8;
      else if (env >= 8'h06) exp_divider = 5'd16;
      else                   exp_divider = 5'd30;
   endfunction

   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      rate_idx = bus.release_rate;
      case (state_q)
         ST_ATTACK:        rate_idx = bus.attack;
         ST_DECAY_SUSTAIN: rate_idx = bus.decay;
         default:          rate_idx = bus.release_rate;
      endcase
      period  = rate_period(rate_idx);
      exp_div = exp_divider(envelope_q);
      level   = {bus.sustain, bus.sustain};
   end

   // A counter left above a newly lowered period runs on to the 15-bit wrap.
   always_comb begin
      rate_step  = 1'b0;
      rate_cnt_d = rate_cnt_q;
      if (tick) begin
         if (rate_cnt_q == period) begin
            rate_cnt_d = '0;
            rate_step  = 1'b1;
         end else begin
            rate_cnt_d = rate_cnt_q + 15'd1;
         end
      end
   end

   always_comb begin
      env_step  = 1'b0;
      exp_cnt_d = exp_cnt_q;
      if (state_q == ST_ATTACK) begin
         exp_cnt_d = '0;
         env_step  = rate_step;
      end else if (rate_step) begin
         if (exp_cnt_q + 5'd1 >= exp_div) begin
            exp_cnt_d = '0;
            env_step  = 1'b1;
         end else begin
            exp_cnt_d = exp_cnt_q + 5'd1;
         end
      end
   end

   always_comb begin
      gate_dly_d = bus.gate;
      gate_rise  = bus.gate & ~gate_dly_q;
      gate_fall  = ~bus.gate & gate_dly_q;
   end

   // Gate edges override any step pending in the same cycle.
   always_comb begin
      state_d    = state_q;
      envelope_d = envelope_q;
      if (gate_rise || gate_fall) begin
         state_d = gate_rise ? ST_ATTACK : ST_RELEASE;
      end else begin
         case (state_q)
            ST_ATTACK: begin
               if (env_step) begin
                  if (envelope_q != 8'hFF) envelope_d = envelope_q + 8'd1;
                  if (envelope_q >= 8'hFE) state_d = ST_DECAY_SUSTAIN;
               end
            end
            ST_DECAY_SUSTAIN: begin
               if (env_step && (envelope_q > level)) envelope_d = envelope_q - 8'd1;
            end
            default: begin
               if (env_step && (envelope_q != 8'h00)) envelope_d = envelope_q - 8'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RELEASE;
         presc_q    <= '0;
         rate_cnt_q <= '0;
         exp_cnt_q  <= '0;
         envelope_q <= '0;
         gate_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         envelope_q <= envelope_d;
         gate_dly_q <= gate_dly_d;
         if (gate_rise || gate_fall) begin
            rate_cnt_q <= '0;
            exp_cnt_q  <= '0;
         end else begin
            rate_cnt_q <= rate_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
         end
      end
   end

   assign bus.envelope  = envelope_q;
   assign bus.env_state = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope: full ADSR cycle, regate,
// rate-counter wrap and the prescaled tick.
module tb_adsr_envelope;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   adsr_envelope_if bus ();
   adsr_envelope_if bus2 ();

   adsr_envelope #(.CLK_DIV(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   adsr_envelope #(.CLK_DIV(50)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic g, input logic [3:0] a,
                                input logic [3:0] d, input logic [3:0] s, input logic [3:0] r);
      if (which == 0) begin
         bus.gate = g; bus.attack = a; bus.decay = d; bus.sustain = s; bus.release_rate = r;
      end else begin
         bus2.gate = g; bus2.attack = a; bus2.decay = d; bus2.sustain = s; bus2.release_rate = r;
      end
   endtask

   function automatic logic [7:0] envOf(input int which);
      return (which == 0) ? bus.envelope : bus2.envelope;
   endfunction

   function automatic int nearOr(input int obs, input int exp, input int tol);
      return (obs >= exp - tol && obs <= exp + tol) ? exp : obs;
   endfunction

   function automatic int expDiv(input logic [7:0] v);
      if (v >= 8'h5D) return 1;
      if (v >= 8'h36) return 2;
      if (v >= 8'h1A) return 4;
      if (v >= 8'h0E) return 8;
      if (v >= 8'h06) return 16;
      return 30;
   endfunction

   // Called at a negedge; returns clocks until the envelope changes, or -1 on timeout.
   task automatic waitChange(input int which, input int limit, output int dt);
      logic [7:0] start;
      int n;
      start = envOf(which);
      n = 0;
      while (envOf(which) == start && n < limit) begin
         @(negedge clk);
         n++;
      end
      dt = (envOf(which) == start) ? -1 : n;
   endtask

   task automatic waitUntil(input logic [7:0] target, input int limit);
      int dt;
      int n;
      dt = 0;
      n = 0;
      while (bus.envelope != target && dt >= 0 && n < 400) begin
         waitChange(0, limit, dt);
         n++;
      end
   endtask

   initial begin
      int dt, t0, steps, bad;
      logic [7:0] prevEnv;
      logic [1:0] prevState;

      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0);
      applyStimulus(1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      repeat (3) @(negedge clk);
      checkOutput("reset_envelope", bus.envelope, 8'h00);
      checkOutput("reset_state", bus.env_state, 2);
      checkOutput("reset_envelope_div50", bus2.envelope, 8'h00);
      checkOutput("reset_state_div50", bus2.env_state, 2);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted in the middle of an attack
      bus.gate = 1'b1;
      repeat (300) @(negedge clk);
      checkOutput("pre_reset_attacking", (bus.envelope > 8'h10) ? 1 : 0, 1);
      rst_n = 1'b0;
      bus.gate = 1'b0;
      @(negedge clk);
      checkOutput("midattack_reset_env", bus.envelope, 8'h00);
      checkOutput("midattack_reset_state", bus.env_state, 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("after_reset_env", bus.envelope, 8'h00);

      // Attack 0x00 -> 0xFF with attack=0
      applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      t0 = cyc; steps = 0; bad = 0; dt = 0; prevState = bus.env_state;
      while (bus.envelope != 8'hFF && dt >= 0 && steps < 300) begin
         prevState = bus.env_state;
         prevEnv = bus.envelope;
         waitChange(0, 40, dt);
         if (dt >= 0) begin
            steps++;
            if (dt != ((steps == 1) ? 11 : 10) || bus.envelope != prevEnv + 8'd1) bad++;
         end
      end
      checkOutput("attack_reach_ff", bus.envelope, 8'hFF);
      checkOutput("attack_steps", steps, 255);
      checkOutput("attack_bad_intervals", bad, 0);
      checkOutput("attack_total_clks", nearOr(cyc - t0, 2551, 2), 2551);
      checkOutput("attack_state_before_ff", prevState, 0);
      checkOutput("attack_state_at_ff", bus.env_state, 1);

      // Decay 0xFF -> 0x88 with decay=0, sustain=8
      steps = 0; bad = 0; dt = 0;
      while (bus.envelope != 8'h88 && dt >= 0 && steps < 300) begin
         prevEnv = bus.envelope;
         waitChange(0, 40, dt);
         if (dt >= 0) begin
            steps++;
            if (dt != 10 || bus.envelope != prevEnv - 8'd1) bad++;
         end
      end
      checkOutput("decay_reach_level", bus.envelope, 8'h88);
      checkOutput("decay_steps", steps, 119);
      checkOutput("decay_bad_intervals", bad, 0);
      repeat (5000) @(negedge clk);
      checkOutput("sustain_hold_env", bus.envelope, 8'h88);
      checkOutput("sustain_hold_state", bus.env_state, 1);
      applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'hF, 4'd0);
      repeat (1000) @(negedge clk);
      checkOutput("sustain_raised_no_climb", bus.envelope, 8'h88);

      // Release 0x88 -> 0x00 with release=0 through all exponential bands
      applyStimulus(0, 1'b0, 4'd0, 4'd0, 4'hF, 4'd0);
      t0 = cyc; steps = 0; bad = 0; dt = 0;
      while (bus.envelope != 8'h00 && dt >= 0 && steps < 300) begin
         prevEnv = bus.envelope;
         waitChange(0, 400, dt);
         if (dt >= 0) begin
            steps++;
            if (dt != 10 * expDiv(prevEnv) + ((steps == 1) ? 1 : 0)) begin
               bad++;
               $display("[TB] release interval at 0x%02h: %0d clks", prevEnv, dt);
            end
         end
      end
      checkOutput("release_reach_zero", bus.envelope, 8'h00);
      checkOutput("release_steps", steps, 136);
      checkOutput("release_bad_intervals", bad, 0);
      checkOutput("release_total_clks", cyc - t0, 6081);
      checkOutput("release_state", bus.env_state, 2);
      repeat (10000) @(negedge clk);
      checkOutput("release_hold_zero", bus.envelope, 8'h00);

      // Regate during release at 0x40
      applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      waitUntil(8'hFF, 40);
      waitUntil(8'h88, 40);
      checkOutput("regate_setup_level", bus.envelope, 8'h88);
      applyStimulus(0, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0);
      waitUntil(8'h40, 100);
      checkOutput("regate_reach_40", bus.envelope, 8'h40);
      applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      waitChange(0, 40, dt);
      checkOutput("regate_first_dt", dt, 11);
      checkOutput("regate_first_env", bus.envelope, 8'h41);
      checkOutput("regate_state", bus.env_state, 0);
      waitChange(0, 40, dt);
      checkOutput("regate_second_dt", dt, 10);
      checkOutput("regate_second_env", bus.envelope, 8'h42);

      // Lowering the decay rate with rate_cnt above the new period forces a wrap
      applyStimulus(0, 1'b1, 4'd0, 4'd15, 4'd8, 4'd0);
      waitUntil(8'hFF, 40);
      checkOutput("wrap_setup_ff", bus.envelope, 8'hFF);
      repeat (20000) @(negedge clk);
      checkOutput("wrap_slow_decay_hold", bus.envelope, 8'hFF);
      applyStimulus(0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      waitChange(0, 14000, dt);
      checkOutput("wrap_first_dt", nearOr(dt, 12778, 1), 12778);
      checkOutput("wrap_first_env", bus.envelope, 8'hFE);
      waitChange(0, 40, dt);
      checkOutput("wrap_second_dt", dt, 10);
      checkOutput("wrap_second_env", bus.envelope, 8'hFD);

      // CLK_DIV=50 instance: one attack step per 500 clocks
      checkOutput("div50_idle_env", bus2.envelope, 8'h00);
      applyStimulus(1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      waitChange(1, 700, dt);
      checkOutput("div50_first_dt", nearOr(dt, 476, 26), 476);
      checkOutput("div50_first_env", bus2.envelope, 8'h01);
      waitChange(1, 700, dt);
      checkOutput("div50_second_dt", dt, 500);
      waitChange(1, 700, dt);
      checkOutput("div50_third_dt", dt, 500);
      checkOutput("div50_third_env", bus2.envelope, 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish within 200000 clocks");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
